// File: rtl/pe_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pe_job_sequencer
// Description : Runs one convolution job on a single PE. It fetches filter
//               words, then IFM words, from a 1-cycle-latency source memory,
//               streams them into the PE buffers under ready handshakes,
//               pulses the PE start, and forwards PE results to a sink.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_job_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int S          = 2,
  parameter int F          = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [S-1:0]          cfg_stride,
  input  logic [F-1:0]          cfg_filter_size,
  input  logic [ADDR_WIDTH-1:0] cfg_fil_base,
  input  logic [CNT_WIDTH-1:0]  cfg_fil_len,
  input  logic [ADDR_WIDTH-1:0] cfg_ifm_base,
  input  logic [CNT_WIDTH-1:0]  cfg_row_len,
  input  logic [CNT_WIDTH-1:0]  cfg_num_rows,
  output logic                  busy,
  output logic                  job_done,
  output logic                  cfg_err,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  pe_start,
  output logic [S-1:0]          pe_stride,
  output logic [F-1:0]          pe_filter_size,
  output logic                  pe_w_en_fil,
  output logic [DATA_WIDTH-1:0] pe_data_fil,
  input  logic                  pe_ready_fil,
  output logic                  pe_w_en_ifm,
  output logic [DATA_WIDTH+1:0] pe_data_ifm,
  input  logic                  pe_ready_ifm,
  input  logic                  pe_done,
  input  logic                  pe_valid,
  output logic                  pe_r_en,
  input  logic [DATA_WIDTH-1:0] pe_out,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_FIL  = 3'd1,
    KICK      = 3'd2,
    LOAD_IFM  = 3'd3,
    WAIT_DONE = 3'd4,
    FIN       = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0]  c_CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;

  // Job configuration captured at accept time
  logic [ADDR_WIDTH-1:0] r_fil_base;
  logic [ADDR_WIDTH-1:0] r_ifm_base;
  logic [CNT_WIDTH-1:0]  r_fil_len;
  logic [CNT_WIDTH-1:0]  r_row_len;
  logic [CNT_WIDTH-1:0]  r_num_rows;

  // Issue side: offset from base, filter count, IFM col/row and done flag
  logic [ADDR_WIDTH-1:0] r_rd_off;
  logic [CNT_WIDTH-1:0]  r_rd_cnt;
  logic [CNT_WIDTH-1:0]  r_rd_col;
  logic [CNT_WIDTH-1:0]  r_rd_row;
  logic                  r_rd_done;

  // Write side: filter count and IFM col/row used for the eor/eof tags
  logic [CNT_WIDTH-1:0]  r_wr_cnt;
  logic [CNT_WIDTH-1:0]  r_wr_col;
  logic [CNT_WIDTH-1:0]  r_wr_row;

  logic                  r_inflight;   // a read issued last cycle returns now
  logic                  r_hold_vld;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_done_seen;  // pe_done arrived before the last IFM write

  logic                  w_loading;
  logic                  w_ready;
  logic                  w_rd_left;
  logic                  w_issue;
  logic                  w_write;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_eor;
  logic                  w_eof;
  logic                  w_fil_last_wr;
  logic                  w_ifm_last_wr;
  logic                  w_cfg_zero;

  // Result path is a straight pass-through, independent of the job state
  assign out_data  = pe_out;
  assign out_valid = pe_valid;
  assign pe_r_en   = pe_valid & out_ready;

  assign w_loading = (r_state == LOAD_FIL) || (r_state == LOAD_IFM);
  assign w_ready   = (r_state == LOAD_FIL) ? pe_ready_fil : pe_ready_ifm;
  assign w_rd_left = (r_state == LOAD_FIL) ? (r_rd_cnt != r_fil_len) : !r_rd_done;

  // A new read is only launched when its return can always be absorbed: the
  // hold slot is free and the target is ready now. Any earlier return is then
  // either written this cycle or parked, never both a park and a new return.
  assign w_issue   = w_loading && w_rd_left && !r_hold_vld && w_ready;
  assign w_write   = w_loading && (r_hold_vld || r_inflight) && w_ready;
  assign w_wdata   = r_hold_vld ? r_hold : mem_rdata;
  assign w_rd_addr = ((r_state == LOAD_FIL) ? r_fil_base : r_ifm_base) + r_rd_off;

  assign mem_rd_en = w_issue;
  assign mem_addr  = w_issue ? w_rd_addr : '0;

  assign w_eor = (r_wr_col == (r_row_len - c_CNT_ONE));
  assign w_eof = w_eor && (r_wr_row == (r_num_rows - c_CNT_ONE));

  assign pe_w_en_fil = w_write && (r_state == LOAD_FIL);
  assign pe_data_fil = pe_w_en_fil ? w_wdata : '0;
  assign pe_w_en_ifm = w_write && (r_state == LOAD_IFM);
  assign pe_data_ifm = pe_w_en_ifm ? {w_eof, w_eor, w_wdata} : '0;

  assign w_fil_last_wr = pe_w_en_fil && (r_wr_cnt == (r_fil_len - c_CNT_ONE));
  assign w_ifm_last_wr = pe_w_en_ifm && w_eof;
  assign w_cfg_zero    = (cfg_fil_len == '0) || (cfg_row_len == '0) || (cfg_num_rows == '0);

  // Job FSM, fetch bookkeeping and registered control outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      busy           <= 1'b0;
      job_done       <= 1'b0;
      cfg_err        <= 1'b0;
      pe_start       <= 1'b0;
      pe_stride      <= '0;
      pe_filter_size <= '0;
      r_fil_base     <= '0;
      r_ifm_base     <= '0;
      r_fil_len      <= '0;
      r_row_len      <= '0;
      r_num_rows     <= '0;
      r_rd_off       <= '0;
      r_rd_cnt       <= '0;
      r_rd_col       <= '0;
      r_rd_row       <= '0;
      r_rd_done      <= 1'b0;
      r_wr_cnt       <= '0;
      r_wr_col       <= '0;
      r_wr_row       <= '0;
      r_inflight     <= 1'b0;
      r_hold_vld     <= 1'b0;
      r_hold         <= '0;
      r_done_seen    <= 1'b0;
    end else begin
      cfg_err    <= 1'b0;
      job_done   <= 1'b0;
      pe_start   <= 1'b0;
      r_inflight <= w_issue;

      // Park a return the target could not take; drain when it becomes ready
      if (w_loading && r_inflight && !w_ready) begin
        r_hold_vld <= 1'b1;
        r_hold     <= mem_rdata;
      end else if (w_loading && r_hold_vld && w_ready) begin
        r_hold_vld <= 1'b0;
      end

      if (w_issue) begin
        r_rd_off <= r_rd_off + c_ADDR_ONE;
        r_rd_cnt <= r_rd_cnt + c_CNT_ONE;
        if (r_state == LOAD_IFM) begin
          if (r_rd_col == (r_row_len - c_CNT_ONE)) begin
            r_rd_col <= '0;
            if (r_rd_row == (r_num_rows - c_CNT_ONE)) begin
              r_rd_done <= 1'b1;
            end else begin
              r_rd_row <= r_rd_row + c_CNT_ONE;
            end
          end else begin
            r_rd_col <= r_rd_col + c_CNT_ONE;
          end
        end
      end

      if (pe_w_en_fil) begin
        r_wr_cnt <= r_wr_cnt + c_CNT_ONE;
      end
      if (pe_w_en_ifm) begin
        if (w_eor) begin
          r_wr_col <= '0;
          r_wr_row <= r_wr_row + c_CNT_ONE;
        end else begin
          r_wr_col <= r_wr_col + c_CNT_ONE;
        end
      end

      if (((r_state == KICK) || (r_state == LOAD_IFM)) && pe_done) begin
        r_done_seen <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (cfg_start) begin
            if (w_cfg_zero) begin
              cfg_err <= 1'b1;
            end else begin
              pe_stride      <= cfg_stride;
              pe_filter_size <= cfg_filter_size;
              r_fil_base     <= cfg_fil_base;
              r_fil_len      <= cfg_fil_len;
              r_ifm_base     <= cfg_ifm_base;
              r_row_len      <= cfg_row_len;
              r_num_rows     <= cfg_num_rows;
              busy           <= 1'b1;
              r_state        <= LOAD_FIL;
            end
          end
        end
        LOAD_FIL: begin
          if (w_fil_last_wr) begin
            pe_start <= 1'b1;
            r_state  <= KICK;
          end
        end
        KICK: begin
          r_rd_off  <= '0;
          r_rd_cnt  <= '0;
          r_rd_col  <= '0;
          r_rd_row  <= '0;
          r_rd_done <= 1'b0;
          r_wr_cnt  <= '0;
          r_wr_col  <= '0;
          r_wr_row  <= '0;
          r_state   <= LOAD_IFM;
        end
        LOAD_IFM: begin
          if (w_ifm_last_wr) begin
            r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (pe_done || r_done_seen) begin
            job_done <= 1'b1;
            busy     <= 1'b0;
            r_state  <= FIN;
          end
        end
        FIN: begin
          r_rd_off    <= '0;
          r_rd_cnt    <= '0;
          r_rd_col    <= '0;
          r_rd_row    <= '0;
          r_rd_done   <= 1'b0;
          r_wr_cnt    <= '0;
          r_wr_col    <= '0;
          r_wr_row    <= '0;
          r_done_seen <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/pe_job_sequencer.md
Name: pe_job_sequencer

Overview:
Sequences one convolution job on a single processing element (PE).
- Accepts a job descriptor and fetches filter words, then IFM words, from a shared on-chip source memory with fixed 1-cycle read latency.
- Writes the words into the PE's filter and IFM buffers under their ready handshakes and pulses the PE start.
- Forwards PE results to a downstream valid/ready sink and reports job completion.

Parameters:
DATA_WIDTH, 8, width of one data word
S, 2, width of stride field
F, 2, width of filter-size field
ADDR_WIDTH, 10, source memory address width
CNT_WIDTH, 10, width of length/row counters

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cfg_start  in  1  job request; sampled only in IDLE
cfg_stride  in  S  stride for the job
cfg_filter_size  in  F  filter size for the job
cfg_fil_base  in  ADDR_WIDTH  first filter word address
cfg_fil_len  in  CNT_WIDTH  number of filter words
cfg_ifm_base  in  ADDR_WIDTH  first IFM word address
cfg_row_len  in  CNT_WIDTH  IFM words per row
cfg_num_rows  in  CNT_WIDTH  IFM rows
busy  out  1  high from accepted start until job_done
job_done  out  1  one-cycle completion pulse
cfg_err  out  1  one-cycle pulse: start rejected because a length is zero
mem_rd_en  out  1  source memory read strobe
mem_addr  out  ADDR_WIDTH  read address
mem_rdata  in  DATA_WIDTH  read data, valid the cycle after mem_rd_en
pe_start  out  1  one-cycle PE start pulse
pe_stride  out  S  latched stride
pe_filter_size  out  F  latched filter size
pe_w_en_fil  out  1  filter write strobe
pe_data_fil  out  DATA_WIDTH  filter write data
pe_ready_fil  in  1  PE can accept a filter word
pe_w_en_ifm  out  1  IFM write strobe
pe_data_ifm  out  DATA_WIDTH+2  {eof, eor, data}
pe_ready_ifm  in  1  PE can accept an IFM word
pe_done  in  1  PE finished job
pe_valid  in  1  PE result available
pe_r_en  out  1  PE result read
pe_out  in  DATA_WIDTH  PE result
out_data  out  DATA_WIDTH  result to sink
out_valid  out  1  result valid
out_ready  in  1  sink ready

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE and all counters clear.
  - All registered outputs go to 0: busy, job_done, cfg_err, mem_rd_en, mem_addr, pe_start, pe_stride, pe_filter_size, pe_w_en_*, pe_data_*.
  - The hold register is invalidated.
  - Reset mid-job abandons the job silently; no job_done is generated.
- Result path is combinational in every state:
  - out_data = pe_out
  - out_valid = pe_valid
  - pe_r_en = pe_valid & out_ready
- States: IDLE, LOAD_FIL, KICK, LOAD_IFM, WAIT_DONE, FIN.
- IDLE:
  - On cfg_start with any of fil_len, row_len or num_rows equal to 0: pulse cfg_err next cycle and stay in IDLE.
  - Otherwise latch all cfg_* inputs (pe_stride and pe_filter_size update from this latch), set busy, and go to LOAD_FIL.
  - cfg_start outside IDLE is ignored.
- Fetch engine, shared by LOAD_FIL and LOAD_IFM:
  - A read issues (mem_rd_en=1) in cycle t only if words remain to fetch, the hold register is empty, no read returns in t+1 that would need holding, and the target ready is 1 in t.
  - Data returned in t+1 is written to the PE with w_en=1 in t+1 if target ready is 1 in t+1. Otherwise it is captured in the one-entry hold register.
  - The hold register drains to the PE on the first cycle ready=1 and has priority over new returns.
  - No word is lost or duplicated. Max throughput is 1 word/cycle while ready stays high.
  - Addresses are base + index, wrapping modulo 2^ADDR_WIDTH.
- LOAD_FIL:
  - Fetches cfg_fil_len words to the filter port.
  - Goes to KICK after the last filter word has been written, not merely issued.
- KICK: pe_start=1 for exactly one cycle, then go to LOAD_IFM.
- LOAD_IFM:
  - Fetches row_len*num_rows words in row-major order, with column counter col and row counter row.
  - eor=1 on the word with col==row_len-1.
  - eof=1 only on the final word (last col of last row).
  - After the last IFM write, go to WAIT_DONE.
- WAIT_DONE: on pe_done=1 go to FIN. A pe_done arriving during LOAD_IFM is held in a sticky flag and honoured after the last write.
- FIN: job_done=1 for one cycle, busy drops in the same cycle, and the state returns to IDLE. A new job can be accepted the next cycle.
- Simultaneous events:
  - If ready falls in the same cycle a read returns, the data goes to the hold register.
  - If cfg_start arrives with rst_n=0, reset wins.

Test Plan:
1. fil_base=0x010, fil_len=4, ifm_base=0x100, row_len=3, num_rows=2, readies tied 1 ->
   - pe_w_en_fil pulses on addresses 0x010–0x013.
   - pe_start occurs once, one cycle after the 4th filter write.
   - 6 IFM writes follow with eor on words 3 and 6, eof only on word 6.
   - job_done follows pe_done by 1 cycle.
2. pe_ready_fil toggles 1,0,0,1 every cycle with fil_len=5 -> exactly 5 filter writes, in address order, none duplicated; the hold register is exercised.
3. cfg_start with row_len=0 -> cfg_err pulses 1 cycle, no mem_rd_en, busy stays 0.
4. cfg_start pulsed again during LOAD_IFM -> ignored; latched config unchanged; a single job_done.
5. rst_n=0 during LOAD_IFM after 2 of 6 words -> next cycle all outputs 0, state IDLE, no job_done; a subsequent job runs correctly from word 0.
6. Result path: pe_valid=1 with out_ready=0 for 3 cycles, then 1 -> pe_r_en=0 for 3 cycles, then 1; out_data equals pe_out; ifm_base=0x3FE wraps addresses to 0x000.
